// File: rtl/nand_mon_pkg.sv
// Shared types and constants for the NAND channel operation monitor.
// Optype/state encodings and read-port field addresses.
package nand_mon_pkg;

  typedef enum logic [1:0] {
    OP_PROG  = 2'd0,
    OP_READ  = 2'd1,
    OP_ERASE = 2'd2
  } optype_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TMO  = 2'd2
  } state_e;

  localparam logic [2:0] F_LAST   = 3'd0;
  localparam logic [2:0] F_MAX    = 3'd1;
  localparam logic [2:0] F_PROG   = 3'd2;
  localparam logic [2:0] F_READ   = 3'd3;
  localparam logic [2:0] F_ERASE  = 3'd4;
  localparam logic [2:0] F_FAIL   = 3'd5;
  localparam logic [2:0] F_STATUS = 3'd6;

  function automatic logic multi_hot3(
    input logic [2:0] v
  );
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Strobe vector is {erase, read, prog}
  function automatic optype_e op_of(
    input logic [2:0] v
  );
    if (v[1])      return OP_READ;
    else if (v[2]) return OP_ERASE;
    else           return OP_PROG;
  endfunction

  function automatic logic [2:0] op_mask(
    input optype_e op
  );
    case (op)
      OP_PROG:  return 3'b001;
      OP_READ:  return 3'b010;
      OP_ERASE: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/nand_op_monitor_way.sv
// One-way operation monitor: IDLE/BUSY/TMO tracker with latency,
// per-type op counts, fail count and sticky timeout/protocol flags.
module nand_way_monitor
  import nand_mon_pkg::*;
#(
  parameter int               LAT_W   = 24,
  parameter int               CNT_W   = 16,
  parameter logic [LAT_W-1:0] TIMEOUT = LAT_W'(5000000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       start_i,
  input  logic [2:0]       end_i,
  input  logic             fail_i,
  input  logic             clr_i,
  output logic [LAT_W-1:0] last_lat_o,
  output logic [LAT_W-1:0] max_lat_o,
  output logic [CNT_W-1:0] prog_cnt_o,
  output logic [CNT_W-1:0] read_cnt_o,
  output logic [CNT_W-1:0] erase_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [4:0]       status_o,
  output logic             busy_o,
  output logic             event_o
);

  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  optype_e          optype_q, optype_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             tmo_q, tmo_d;
  logic             perr_q, perr_d;
  logic             event_q, event_d;

  logic             active;
  logic [2:0]       mask;
  logic             end_hit;
  logic             end_bad;
  logic             one_start;
  logic             can_start;
  logic             perr_evt;
  logic [LAT_W-1:0] lat_inc;

  always_comb begin
    active    = (state_q != ST_IDLE);
    mask      = active ? op_mask(optype_q) : 3'b000;
    end_hit   = |(end_i & mask);
    end_bad   = |(end_i & ~mask);
    one_start = |start_i && !multi_hot3(start_i);
    can_start = one_start && (!active || end_hit);
    perr_evt  = end_bad
              | (fail_i & ~|end_i)
              | multi_hot3(start_i)
              | (|start_i & active & ~end_hit);
    lat_inc   = (&lat_q) ? lat_q : lat_q + LAT_ONE;

    state_d  = state_q;
    optype_d = optype_q;
    lat_d    = lat_q;
    event_d  = 1'b0;
    // Clear first so a coincident completion lands on zeroed stats
    last_d   = clr_i ? '0 : last_q;
    max_d    = clr_i ? '0 : max_q;
    pcnt_d   = clr_i ? '0 : pcnt_q;
    rcnt_d   = clr_i ? '0 : rcnt_q;
    ecnt_d   = clr_i ? '0 : ecnt_q;
    fcnt_d   = clr_i ? '0 : fcnt_q;
    tmo_d    = clr_i ? 1'b0 : tmo_q;
    perr_d   = (clr_i ? 1'b0 : perr_q) | perr_evt;

    if (end_hit) begin
      state_d = ST_IDLE;
      event_d = 1'b1;
      last_d  = lat_q;
      if (lat_q > max_d) max_d = lat_q;
      unique case (optype_q)
        OP_PROG:  pcnt_d = cnt_inc(pcnt_d);
        OP_READ:  rcnt_d = cnt_inc(rcnt_d);
        OP_ERASE: ecnt_d = cnt_inc(ecnt_d);
        default:  ;
      endcase
      if (fail_i) fcnt_d = cnt_inc(fcnt_d);
    end else if (active) begin
      lat_d = lat_inc;
      if (state_q == ST_BUSY && lat_inc == TIMEOUT) begin
        state_d = ST_TMO;
        tmo_d   = 1'b1;
        event_d = 1'b1;
      end
    end

    if (can_start) begin
      state_d  = ST_BUSY;
      optype_d = op_of(start_i);
      lat_d    = LAT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      optype_q <= OP_PROG;
      lat_q    <= '0;
      last_q   <= '0;
      max_q    <= '0;
      pcnt_q   <= '0;
      rcnt_q   <= '0;
      ecnt_q   <= '0;
      fcnt_q   <= '0;
      tmo_q    <= 1'b0;
      perr_q   <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      optype_q <= optype_d;
      lat_q    <= lat_d;
      last_q   <= last_d;
      max_q    <= max_d;
      pcnt_q   <= pcnt_d;
      rcnt_q   <= rcnt_d;
      ecnt_q   <= ecnt_d;
      fcnt_q   <= fcnt_d;
      tmo_q    <= tmo_d;
      perr_q   <= perr_d;
      event_q  <= event_d;
    end
  end

  assign last_lat_o  = last_q;
  assign max_lat_o   = max_q;
  assign prog_cnt_o  = pcnt_q;
  assign read_cnt_o  = rcnt_q;
  assign erase_cnt_o = ecnt_q;
  assign fail_cnt_o  = fcnt_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign event_o     = event_q;
  assign status_o    = {perr_q, tmo_q, optype_q, busy_o};

endmodule

// File: rtl/nand_op_monitor.sv
// Per-way NAND operation monitor: NWAY way trackers plus a
// registered read port selecting {way, field}.
module nand_op_monitor
  import nand_mon_pkg::*;
#(
  parameter int               NWAY    = 8,
  parameter int               LAT_W   = 24,
  parameter int               CNT_W   = 16,
  parameter logic [LAT_W-1:0] TIMEOUT = 24'd5000000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NWAY-1:0] PROG_START_I,
  input  logic [NWAY-1:0] PROG_END_I,
  input  logic [NWAY-1:0] READ_START_I,
  input  logic [NWAY-1:0] READ_END_I,
  input  logic [NWAY-1:0] ERASE_START_I,
  input  logic [NWAY-1:0] ERASE_END_I,
  input  logic [NWAY-1:0] OP_FAIL_I,
  input  logic [NWAY-1:0] CLR_I,
  input  logic            RD_EN_I,
  input  logic [5:0]      RD_ADDR_I,
  output logic [31:0]     RD_DATA_O,
  output logic            RD_VALID_O,
  output logic [NWAY-1:0] EVENT_O,
  output logic [NWAY-1:0] BUSY_O
);

  logic [LAT_W-1:0] last_lat [NWAY];
  logic [LAT_W-1:0] max_lat  [NWAY];
  logic [CNT_W-1:0] prog_cnt [NWAY];
  logic [CNT_W-1:0] read_cnt [NWAY];
  logic [CNT_W-1:0] erase_cnt[NWAY];
  logic [CNT_W-1:0] fail_cnt [NWAY];
  logic [4:0]       status   [NWAY];
  logic             busy_w   [NWAY];
  logic             event_w  [NWAY];

  for (genvar g = 0; g < NWAY; g++) begin : g_way
    nand_way_monitor #(
      .LAT_W   (LAT_W),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_way (
      .clk         (CLK),
      .rst         (RESET),
      .start_i     ({ERASE_START_I[g], READ_START_I[g],
                     PROG_START_I[g]}),
      .end_i       ({ERASE_END_I[g], READ_END_I[g],
                     PROG_END_I[g]}),
      .fail_i      (OP_FAIL_I[g]),
      .clr_i       (CLR_I[g]),
      .last_lat_o  (last_lat[g]),
      .max_lat_o   (max_lat[g]),
      .prog_cnt_o  (prog_cnt[g]),
      .read_cnt_o  (read_cnt[g]),
      .erase_cnt_o (erase_cnt[g]),
      .fail_cnt_o  (fail_cnt[g]),
      .status_o    (status[g]),
      .busy_o      (busy_w[g]),
      .event_o     (event_w[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NWAY; i++) begin
      EVENT_O[i] = event_w[i];
      BUSY_O[i]  = busy_w[i];
    end
  end

  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [2:0]  rd_way;

  // Sampled before this edge's updates, so reads see pre-update values
  always_comb begin
    rd_way     = RD_ADDR_I[5:3];
    rd_valid_d = RD_EN_I;
    rd_data_d  = '0;
    if (RD_EN_I && int'(rd_way) < NWAY) begin
      unique case (RD_ADDR_I[2:0])
        F_LAST:   rd_data_d = 32'(last_lat[rd_way]);
        F_MAX:    rd_data_d = 32'(max_lat[rd_way]);
        F_PROG:   rd_data_d = 32'(prog_cnt[rd_way]);
        F_READ:   rd_data_d = 32'(read_cnt[rd_way]);
        F_ERASE:  rd_data_d = 32'(erase_cnt[rd_way]);
        F_FAIL:   rd_data_d = 32'(fail_cnt[rd_way]);
        F_STATUS: rd_data_d = 32'(status[rd_way]);
        default:  rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RD_DATA_O  = rd_data_q;
  assign RD_VALID_O = rd_valid_q;

endmodule

// File: tb/tb_nand_op_monitor.sv
// Bench for nand_op_monitor: directed scenarios then randomized
// traffic against a cycle-stamp reference model.
module tb_nand_op_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prog_s, prog_e, read_s, read_e;
  logic [7:0]  erase_s, erase_e, fail, clr;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [7:0]  ev, busy;

  logic [7:0]  t_prog_s, t_prog_e;
  logic        t_rd_en;
  logic [5:0]  t_rd_addr;
  logic [31:0] t_rd_data;
  logic        t_rd_valid;
  logic [7:0]  t_ev, t_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nand_op_monitor dut (
    .CLK(clk), .RESET(rst),
    .PROG_START_I(prog_s), .PROG_END_I(prog_e),
    .READ_START_I(read_s), .READ_END_I(read_e),
    .ERASE_START_I(erase_s), .ERASE_END_I(erase_e),
    .OP_FAIL_I(fail), .CLR_I(clr),
    .RD_EN_I(rd_en), .RD_ADDR_I(rd_addr),
    .RD_DATA_O(rd_data), .RD_VALID_O(rd_valid),
    .EVENT_O(ev), .BUSY_O(busy)
  );

  nand_op_monitor #(.TIMEOUT(24'd50)) dut_t (
    .CLK(clk), .RESET(rst),
    .PROG_START_I(t_prog_s), .PROG_END_I(t_prog_e),
    .READ_START_I(8'h00), .READ_END_I(8'h00),
    .ERASE_START_I(8'h00), .ERASE_END_I(8'h00),
    .OP_FAIL_I(8'h00), .CLR_I(8'h00),
    .RD_EN_I(t_rd_en), .RD_ADDR_I(t_rd_addr),
    .RD_DATA_O(t_rd_data), .RD_VALID_O(t_rd_valid),
    .EVENT_O(t_ev), .BUSY_O(t_busy)
  );

  // Reference model: per-way stats, start stamped with bench cycle
  int m_busy[8], m_op[8], m_st[8], m_last[8], m_max[8];
  int m_pc[8], m_rc[8], m_ec[8], m_fc[8], m_perr[8];

  function automatic logic [31:0] mfield(int w, int f);
    case (f)
      0: return m_last[w];
      1: return m_max[w];
      2: return m_pc[w];
      3: return m_rc[w];
      4: return m_ec[w];
      5: return m_fc[w];
      6: return m_perr[w] * 16 + m_op[w] * 2 + m_busy[w];
      default: return 0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(int w, int t, logic v);
    case (t)
      0: prog_s[w] = v;
      1: read_s[w] = v;
      default: erase_s[w] = v;
    endcase
  endtask

  task automatic set_end(int w, int t, logic v);
    case (t)
      0: prog_e[w] = v;
      1: read_e[w] = v;
      default: erase_e[w] = v;
    endcase
  endtask

  task automatic idle_in();
    prog_s = '0; prog_e = '0; read_s = '0; read_e = '0;
    erase_s = '0; erase_e = '0; fail = '0; clr = '0;
    rd_en = 1'b0;
  endtask

  task automatic chk_rd(string tag, int w, int f, int exp);
    logic [2:0] wb, fb;
    wb = 3'(w);
    fb = 3'(f);
    rd_en = 1'b1;
    rd_addr = {wb, fb};
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  task automatic do_op(int w, int t, int lat, logic f);
    set_start(w, t, 1'b1);
    @(negedge clk);
    set_start(w, t, 1'b0);
    repeat (lat - 1) @(negedge clk);
    set_end(w, t, 1'b1);
    fail[w] = f;
    @(negedge clk);
    set_end(w, t, 1'b0);
    fail[w] = 1'b0;
  endtask

  initial begin
    int bcnt, ecnt;
    logic        e_valid;
    logic [31:0] e_data;
    logic [7:0]  e_ev, e_busy;

    idle_in();
    rd_addr = '0;
    t_prog_s = '0; t_prog_e = '0; t_rd_en = 1'b0; t_rd_addr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_event", ev, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk_rd("rst_status", 0, 6, 0);

    // Single PROG on way 2, latency 100
    prog_s[2] = 1'b1;
    @(negedge clk);
    prog_s[2] = 1'b0;
    bcnt = 0; ecnt = 0;
    for (int k = 1; k <= 110; k++) begin
      bcnt += int'(busy[2]);
      ecnt += int'(ev[2]);
      prog_e[2] = (k == 100);
      @(negedge clk);
    end
    chk("p_busy_cycles", bcnt, 100);
    chk("p_events", ecnt, 1);
    chk_rd("p_last", 2, 0, 100);
    chk_rd("p_count", 2, 2, 1);
    chk_rd("p_field7", 2, 7, 0);

    // READ latencies on way 5
    do_op(5, 1, 40, 1'b0);
    do_op(5, 1, 90, 1'b0);
    do_op(5, 1, 60, 1'b0);
    chk_rd("r_last", 5, 0, 60);
    chk_rd("r_max", 5, 1, 90);
    chk_rd("r_count", 5, 3, 3);

    // ERASE with coincident fail on way 0
    do_op(0, 2, 25, 1'b1);
    chk_rd("e_count", 0, 4, 1);
    chk_rd("e_fail", 0, 5, 1);
    chk_rd("e_status", 0, 6, 4);

    // Timeout at 50 on the second instance, way 7
    t_prog_s[7] = 1'b1;
    @(negedge clk);
    t_prog_s[7] = 1'b0;
    ecnt = 0;
    for (int k = 1; k <= 75; k++) begin
      if (k <= 69) ecnt += int'(t_ev[7]);
      if (k == 50) begin
        chk("t_vld49", t_rd_valid, 1);
        chk("t_status49", t_rd_data, 1);
      end
      if (k == 51) begin
        chk("t_vld50", t_rd_valid, 1);
        chk("t_status50", t_rd_data, 9);
        chk("t_busy50", t_busy[7], 1);
      end
      if (k == 71) begin
        chk("t_end_event", t_ev[7], 1);
        chk("t_end_busy", t_busy[7], 0);
      end
      t_rd_en = (k == 49 || k == 50);
      t_rd_addr = {3'd7, 3'd6};
      t_prog_e[7] = (k == 70);
      @(negedge clk);
    end
    chk("t_tmo_events", ecnt, 1);
    t_rd_en = 1'b1;
    t_rd_addr = {3'd7, 3'd0};
    @(negedge clk);
    t_rd_en = 1'b0;
    chk("t_last", t_rd_data, 70);

    // Protocol error then back-to-back on way 3
    prog_s[3] = 1'b1;
    @(negedge clk);
    prog_s[3] = 1'b0;
    repeat (9) @(negedge clk);
    read_e[3] = 1'b1;
    @(negedge clk);
    read_e[3] = 1'b0;
    chk_rd("pe_status", 3, 6, 17);
    prog_e[3] = 1'b1;
    read_s[3] = 1'b1;
    @(negedge clk);
    prog_e[3] = 1'b0;
    read_s[3] = 1'b0;
    chk_rd("b2b_prog", 3, 2, 1);
    chk_rd("b2b_status", 3, 6, 19);
    repeat (2) @(negedge clk);
    read_e[3] = 1'b1;
    @(negedge clk);
    read_e[3] = 1'b0;
    chk_rd("b2b_last", 3, 0, 5);
    chk_rd("b2b_read", 3, 3, 1);

    // Reset during a READ on way 1
    read_s[1] = 1'b1;
    @(negedge clk);
    read_s[1] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_valid", rd_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_rd("ar_st1", 1, 6, 0);
    chk_rd("ar_max5", 5, 1, 0);
    chk_rd("ar_fail0", 0, 5, 0);
    chk_rd("ar_last2", 2, 0, 0);
    chk("ar_busy2", busy, 0);
    read_e[1] = 1'b1;
    @(negedge clk);
    read_e[1] = 1'b0;
    chk_rd("ar_perr", 1, 6, 16);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk_rd("clr_status", 1, 6, 0);
    @(negedge clk);

    // Randomized traffic
    foreach (m_busy[i]) begin
      m_busy[i] = 0; m_op[i] = 0; m_st[i] = 0; m_last[i] = 0;
      m_max[i] = 0; m_pc[i] = 0; m_rc[i] = 0; m_ec[i] = 0;
      m_fc[i] = 0; m_perr[i] = 0;
    end
    e_valid = 1'b0; e_data = '0; e_ev = '0; e_busy = '0;
    for (int c = 0; c < 2000; c++) begin
      int rw, rf;
      chk("rnd_valid", rd_valid, e_valid);
      if (e_valid) chk("rnd_data", rd_data, e_data);
      chk("rnd_event", ev, e_ev);
      chk("rnd_busy", busy, e_busy);
      idle_in();
      rd_en = 1'($urandom_range(0, 1));
      rw = $urandom_range(0, 7);
      rf = $urandom_range(0, 7);
      rd_addr = {3'(rw), 3'(rf)};
      e_valid = rd_en;
      e_data = rd_en ? mfield(rw, rf) : 32'd0;
      for (int w = 0; w < 8; w++) begin
        int r;
        r = $urandom_range(0, 63);
        e_ev[w] = 1'b0;
        if ($urandom_range(0, 63) == 0) begin
          clr[w] = 1'b1;
          m_last[w] = 0; m_max[w] = 0; m_pc[w] = 0; m_rc[w] = 0;
          m_ec[w] = 0; m_fc[w] = 0; m_perr[w] = 0;
        end
        if (m_busy[w] != 0) begin
          if (r < 10) begin
            int lat;
            logic f;
            f = ($urandom_range(0, 3) == 0);
            set_end(w, m_op[w], 1'b1);
            fail[w] = f;
            lat = c - m_st[w];
            m_last[w] = lat;
            if (lat > m_max[w]) m_max[w] = lat;
            case (m_op[w])
              0: m_pc[w]++;
              1: m_rc[w]++;
              default: m_ec[w]++;
            endcase
            if (f) m_fc[w]++;
            m_busy[w] = 0;
            e_ev[w] = 1'b1;
          end
        end else if (r < 8) begin
          m_op[w] = $urandom_range(0, 2);
          set_start(w, m_op[w], 1'b1);
          m_busy[w] = 1;
          m_st[w] = c;
        end else if (r == 8) begin
          set_end(w, $urandom_range(0, 2), 1'b1);
          m_perr[w] = 1;
        end else if (r == 9) begin
          fail[w] = 1'b1;
          m_perr[w] = 1;
        end
        e_busy[w] = (m_busy[w] != 0);
      end
      @(negedge clk);
    end
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
